mem_bus_responder: RTL

- Memory-side responder for the processor's memory bus (add_M, toMEM, frmMEM, weM, M_enable).
- Holds on-chip 16-bit word RAM and serves processor reads and writes with a fixed 1-cycle read latency.
- Has a second, lower-priority host port so the image loader/dumper can fill and read memory while the processor is paused or between its accesses.
- Sits beside micro_processor in the top level.

---
 rtl/mem_bus_pkg.sv | 13 +
 rtl/mem_bus_responder_if.sv | 31 +++
 rtl/ram_sp_16.sv | 21 ++
 rtl/mem_bus_responder.sv | 99 +++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus responder slice.
package mem_bus_pkg;

   localparam int DATA_W        = 16;
   localparam int DEPTH_DEFAULT = 1024;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOST_ACC  = 2'd1,
      HOST_RESP = 2'd2
   } host_state_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// Processor memory bus plus the lower-priority host (loader/dumper) port.
interface mem_bus_responder_if;
   import mem_bus_pkg::*;

   logic [DATA_W-1:0] add_M;
   logic [DATA_W-1:0] toMEM;
   logic [DATA_W-1:0] frmMEM;
   logic              weM;
   logic              M_enable;

   logic              host_req;
   logic              host_we;
   logic [DATA_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;

   modport master (
      output add_M, toMEM, weM, M_enable,
      output host_req, host_we, host_addr, host_wdata,
      input  frmMEM, host_gnt, host_rvalid, host_rdata
   );

   modport slave (
      input  add_M, toMEM, weM, M_enable,
      input  host_req, host_we, host_addr, host_wdata,
      output frmMEM, host_gnt, host_rvalid, host_rdata
   );

endinterface

// File: rtl/ram_sp_16.sv
// Synchronous single-port 16-bit RAM, read data registered one cycle after addr.
module ram_sp_16 #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       wdata,
   output logic [15:0]       rdata
);

   logic [15:0] mem [DEPTH];

   // NOTE: storage has no reset so it maps onto block RAM; contents survive rst.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: CPU port always wins, host FSM uses the RAM port when CPU is idle.
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   mem_bus_responder_if.slave bus,
   output logic              oob_err,
   output logic [DATA_W-1:0] wr_count
);

   localparam logic [31:0] DEPTH_U = DEPTH;

   host_state_t       state;
   logic              cpu_ok, host_ok, host_go, oob_hit;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;
   logic              cpu_rd_q, rvalid_q, host_oob_q;
   logic [DATA_W-1:0] frm_hold, host_hold;

   assign cpu_ok  = {16'd0, bus.add_M}     < DEPTH_U;
   assign host_ok = {16'd0, bus.host_addr} < DEPTH_U;
   assign host_go = (state == HOST_ACC) && !bus.M_enable && !rst;
   assign oob_hit = (bus.M_enable && !cpu_ok) || (host_go && !host_ok);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = bus.add_M[ADDR_W-1:0];
      ram_wdata = bus.toMEM;
      if (bus.M_enable) begin
         ram_we = bus.weM && cpu_ok;
      end else if (host_go) begin
         ram_addr  = bus.host_addr[ADDR_W-1:0];
         ram_wdata = bus.host_wdata;
         ram_we    = bus.host_we && host_ok;
      end
   end

   ram_sp_16 #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Fresh RAM data is shown the cycle after a read, then parked in a hold register.
   assign bus.frmMEM      = cpu_rd_q ? ram_rdata : frm_hold;
   assign bus.host_rdata  = rvalid_q ? (host_oob_q ? '0 : ram_rdata) : host_hold;
   assign bus.host_rvalid = rvalid_q;
   assign bus.host_gnt    = host_go;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cpu_rd_q   <= 1'b0;
         frm_hold   <= '0;
         rvalid_q   <= 1'b0;
         host_oob_q <= 1'b0;
         host_hold  <= '0;
         oob_err    <= 1'b0;
         wr_count   <= '0;
      end else begin
         cpu_rd_q <= bus.M_enable && !bus.weM && cpu_ok;
         if (cpu_rd_q) frm_hold <= ram_rdata;
         if (bus.M_enable && !bus.weM && !cpu_ok) frm_hold <= '0;

         rvalid_q <= 1'b0;
         if (rvalid_q) host_hold <= host_oob_q ? '0 : ram_rdata;

         if (oob_hit) oob_err  <= 1'b1;
         if (ram_we)  wr_count <= wr_count + 16'd1;

         case (state)
            IDLE:
               if (bus.host_req && !bus.M_enable) state <= HOST_ACC;
            HOST_ACC:
               if (bus.M_enable || bus.host_we) begin
                  state <= IDLE;
               end else begin
                  state      <= HOST_RESP;
                  rvalid_q   <= 1'b1;
                  host_oob_q <= !host_ok;
               end
            HOST_RESP:
               state <= IDLE;
            default:
               state <= IDLE;
         endcase
      end
   end

endmodule
